// File: rtl/carregador_instrucoes.sv
// Boot loader: copies quantidade words from the HD read port into instruction memory, holding stall_cpu high meanwhile.
// Optional running checksum of the written words is enabled by defining CARREGADOR_CHECKSUM_EN.
module carregador_instrucoes #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio,
  input  logic [31:0]       end_hd,
  input  logic [ADDR_W-1:0] end_base,
  input  logic [ADDR_W:0]   quantidade,
  output logic              hd_req,
  output logic [31:0]       hd_end,
  input  logic              hd_ack,
  input  logic [DATA_W-1:0] hd_dado,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_end,
  output logic [DATA_W-1:0] im_dado,
  output logic              stall_cpu,
  output logic              ocupado,
  output logic              pronto,
  output logic              erro,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {OCIOSO, PEDE, ESCREVE, FIM, ERRO} estado_t;

  localparam logic [7:0]        ESPERA_MAX = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W+1:0] LIMITE     = (ADDR_W+2)'(MEM_DEPTH);

  estado_t           r_estado, w_prox;
  logic [31:0]       r_end_hd;
  logic [ADDR_W-1:0] r_end_im;
  logic [ADDR_W:0]   r_restante;
  logic [7:0]        r_espera;
  logic [DATA_W-1:0] r_dado;
  logic              r_ocupado, r_pronto, r_erro;
  logic              w_aceita;
  logic [ADDR_W+1:0] w_fim_bloco;
  logic              w_fora;
  logic              w_ultimo;

  // A new start is only taken once the previous run has fully retired, including its pronto cycle.
  assign w_aceita    = (r_estado == OCIOSO) && !r_ocupado && inicio;
  assign w_fim_bloco = {2'b00, end_base} + {1'b0, quantidade};
  assign w_fora      = w_fim_bloco > LIMITE;
  assign w_ultimo    = (r_restante == (ADDR_W+1)'(1));

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (w_aceita) begin
          if (quantidade == '0)
            w_prox = FIM;
          else if (w_fora)
            w_prox = ERRO;
          else
            w_prox = PEDE;
        end
      end
      PEDE: begin
        if (hd_ack)
          w_prox = ESCREVE;
        else if (r_espera == ESPERA_MAX)
          w_prox = ERRO;
      end
      ESCREVE: w_prox = w_ultimo ? FIM : PEDE;
      FIM:     w_prox = OCIOSO;
      ERRO:    w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= OCIOSO;
      r_end_hd   <= '0;
      r_end_im   <= '0;
      r_restante <= '0;
      r_espera   <= '0;
      r_dado     <= '0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_pronto <= (r_estado == FIM) || (r_estado == ERRO);
      if (w_aceita) begin
        r_end_hd   <= end_hd;
        r_end_im   <= end_base;
        r_restante <= quantidade;
        r_espera   <= '0;
        r_erro     <= 1'b0;
        r_ocupado  <= 1'b1;
      end else if (r_pronto) begin
        r_ocupado <= 1'b0;
      end
      case (r_estado)
        PEDE: begin
          if (hd_ack)
            r_dado <= hd_dado;
          else
            r_espera <= r_espera + 8'd1;
        end
        ESCREVE: begin
          // Addresses stop on the last word so im_end never steps past the block end.
          if (!w_ultimo) begin
            r_end_hd <= r_end_hd + 32'd1;
            r_end_im <= r_end_im + ADDR_W'(1);
          end
          r_restante <= r_restante - (ADDR_W+1)'(1);
          r_espera   <= '0;
        end
        ERRO:    r_erro <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CARREGADOR_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_checksum <= '0;
    else if (w_aceita)
      r_checksum <= '0;
    else if (r_estado == ESCREVE)
      r_checksum <= r_checksum + r_dado;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign hd_req    = (r_estado == PEDE);
  assign hd_end    = r_end_hd;
  assign im_we     = (r_estado == ESCREVE);
  assign im_end    = r_end_im;
  assign im_dado   = r_dado;
  assign stall_cpu = r_ocupado;
  assign ocupado   = r_ocupado;
  assign pronto    = r_pronto;
  assign erro      = r_erro;

endmodule
